move_arbiter: RTL and testbench

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/game_pkg.sv | 45 ++++
 rtl/move_arbiter_if.sv | 34 +++
 rtl/move_validator.sv | 18 +
 rtl/move_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_move_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe move arbiter slice.
// Holds board geometry, result encodings, the arbiter state enum,
// the default turn timeout and a small turn-decode helper.
package game_pkg;

  localparam int unsigned BOARD_W            = 9;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;
  localparam int unsigned TW_DEF             = 10;

  // Result encoding shared with the external win checker.
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_CATS = 2'd1,
    RES_WINO = 2'd2,
    RES_WINX = 2'd3
  } result_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_X,
    ST_TURN_O,
    ST_COMMIT,
    ST_CHECK,
    ST_OVER
  } state_e;

  // One bit per square, bit 8 top-left ... bit 0 bottom-right.
  typedef logic [BOARD_W-1:0] square_t;

  // Board payload: occupancy plus owner (1 = X, 0 = O) per square.
  typedef struct packed {
    square_t occ_square;
    square_t occ_player;
  } board_t;

  // {X,O} one-hot while a turn is open, 00 otherwise.
  function automatic logic [1:0] turn_code(input state_e s);
    case (s)
      ST_TURN_X: turn_code = 2'b10;
      ST_TURN_O: turn_code = 2'b01;
      default:   turn_code = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Player/board bus of the move arbiter.
// Carries game start, the X and O request channels (req/pos in,
// ack/nak out), the win checker result, and the board/status outputs.
// slave  : arbiter side; master : players + win checker side.
interface move_arbiter_if;
  import game_pkg::*;

  logic        start;
  logic        req_x;
  square_t     pos_x;
  logic        ack_x;
  logic        nak_x;
  logic        req_o;
  square_t     pos_o;
  logic        ack_o;
  logic        nak_o;
  logic [1:0]  win_in;
  square_t     occ_square;
  square_t     occ_player;
  logic [1:0]  turn;
  logic [1:0]  result;
  logic        done;

  modport slave (
    input  start, req_x, pos_x, req_o, pos_o, win_in,
    output ack_x, nak_x, ack_o, nak_o, occ_square, occ_player, turn, result, done
  );

  modport master (
    output start, req_x, pos_x, req_o, pos_o, win_in,
    input  ack_x, nak_x, ack_o, nak_o, occ_square, occ_player, turn, result, done
  );

endinterface

// File: rtl/move_validator.sv
// Combinational move legality check for one player channel.
// Ports: pos (selected square, should be one-hot), occ (occupied squares),
//        valid_c (pos is exactly one-hot and that square is free).
module move_validator
  import game_pkg::*;
(
  input  square_t pos,
  input  square_t occ,
  output logic    valid_c
);

  logic one_hot_c;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_hot_c = (pos != '0) && ((pos & (pos - BOARD_W'(1))) == '0);
  assign valid_c   = one_hot_c && ((pos & occ) == '0);

endmodule

// File: rtl/move_arbiter.sv
// Tic-tac-toe move arbiter: serialises X and O move requests, keeps the
// board, consults an external win checker and enforces a per-turn timeout.
// Ports: clk, reset (synchronous, active-low), bus (move_arbiter_if.slave).
// Parameters: TIMEOUT_CYCLES (turn length limit), TW (turn timer width).
module move_arbiter
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TW             = TW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  move_arbiter_if.slave  bus
);

  // A turn lasts TIMEOUT_CYCLES-1 cycles: the timer reads 0 in the first
  // cycle, so the incremented value reaches TIMEOUT_CYCLES-1 when it reads this.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  square_t       pos_q, pos_d;
  logic          mover_x_q, mover_x_d;
  board_t        board_q, board_d;
  result_e       result_q, result_d;
  logic [1:0]    turn_q, turn_d;
  logic          done_q, done_d;
  logic          ack_x_q, ack_x_d, nak_x_q, nak_x_d;
  logic          ack_o_q, ack_o_d, nak_o_q, nak_o_d;
  logic          armed_x_q, armed_x_d, armed_o_q, armed_o_d;

  logic          valid_x_c, valid_o_c;
  logic          seen_x_c, seen_o_c;
  result_e       win_c;

  move_validator u_val_x (
    .pos     (bus.pos_x),
    .occ     (board_q.occ_square),
    .valid_c (valid_x_c)
  );

  move_validator u_val_o (
    .pos     (bus.pos_o),
    .occ     (board_q.occ_square),
    .valid_c (valid_o_c)
  );

  // A request is only acted on once per high phase of req.
  assign seen_x_c = bus.req_x && armed_x_q;
  assign seen_o_c = bus.req_o && armed_o_q;
  assign win_c    = result_e'(bus.win_in);

  // Next-state, board and handshake decode.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pos_d     = pos_q;
    mover_x_d = mover_x_q;
    board_d   = board_q;
    result_d  = result_q;
    ack_x_d   = 1'b0;
    nak_x_d   = 1'b0;
    ack_o_d   = 1'b0;
    nak_o_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          board_d  = '0;
          result_d = RES_NONE;
          timer_d  = '0;
          state_d  = ST_TURN_X;
        end
      end

      ST_TURN_X: begin
        nak_o_d = seen_o_c;
        if (seen_x_c && valid_x_c) begin
          ack_x_d   = 1'b1;
          pos_d     = bus.pos_x;
          mover_x_d = 1'b1;
          state_d   = ST_COMMIT;
        end else begin
          nak_x_d = seen_x_c;
          if (timer_q == TIMER_LAST) begin
            state_d  = ST_OVER;
            result_d = RES_WINO;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      ST_TURN_O: begin
        nak_x_d = seen_x_c;
        if (seen_o_c && valid_o_c) begin
          ack_o_d   = 1'b1;
          pos_d     = bus.pos_o;
          mover_x_d = 1'b0;
          state_d   = ST_COMMIT;
        end else begin
          nak_o_d = seen_o_c;
          if (timer_q == TIMER_LAST) begin
            state_d  = ST_OVER;
            result_d = RES_WINX;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      ST_COMMIT: begin
        // The mover is still considered on turn; only the opponent is refused.
        nak_x_d = seen_x_c && !mover_x_q;
        nak_o_d = seen_o_c && mover_x_q;
        board_d.occ_square = board_q.occ_square | pos_q;
        board_d.occ_player = mover_x_q ? (board_q.occ_player | pos_q)
                                       : (board_q.occ_player & ~pos_q);
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        nak_x_d = seen_x_c && !mover_x_q;
        nak_o_d = seen_o_c && mover_x_q;
        if (win_c != RES_NONE) begin
          state_d  = ST_OVER;
          result_d = win_c;
        end else begin
          state_d = mover_x_q ? ST_TURN_O : ST_TURN_X;
          timer_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Disarm on any response; re-arm once req has been seen low.
    armed_x_d = (ack_x_d || nak_x_d) ? 1'b0 : (!bus.req_x ? 1'b1 : armed_x_q);
    armed_o_d = (ack_o_d || nak_o_d) ? 1'b0 : (!bus.req_o ? 1'b1 : armed_o_q);

    turn_d = turn_code(state_d);
    done_d = (state_d == ST_OVER);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pos_q     <= '0;
      mover_x_q <= 1'b0;
      board_q   <= '0;
      result_q  <= RES_NONE;
      turn_q    <= 2'b00;
      done_q    <= 1'b0;
      ack_x_q   <= 1'b0;
      nak_x_q   <= 1'b0;
      ack_o_q   <= 1'b0;
      nak_o_q   <= 1'b0;
      armed_x_q <= 1'b1;
      armed_o_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pos_q     <= pos_d;
      mover_x_q <= mover_x_d;
      board_q   <= board_d;
      result_q  <= result_d;
      turn_q    <= turn_d;
      done_q    <= done_d;
      ack_x_q   <= ack_x_d;
      nak_x_q   <= nak_x_d;
      ack_o_q   <= ack_o_d;
      nak_o_q   <= nak_o_d;
      armed_x_q <= armed_x_d;
      armed_o_q <= armed_o_d;
    end
  end

  assign bus.ack_x      = ack_x_q;
  assign bus.nak_x      = nak_x_q;
  assign bus.ack_o      = ack_o_q;
  assign bus.nak_o      = nak_o_q;
  assign bus.occ_square = board_q.occ_square;
  assign bus.occ_player = board_q.occ_player;
  assign bus.turn       = turn_q;
  assign bus.result     = result_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Testbench for move_arbiter: directed game scenarios plus randomized play,
// every cycle compared against a board/phase-level reference model.
module tb_move_arbiter;

  localparam int unsigned TO = 16;
  localparam int P_IDLE = 0, P_TURN = 1, P_COMMIT = 2, P_CHECK = 3, P_OVER = 4;
  localparam int LINES [8][3] = '{'{8,7,6}, '{5,4,3}, '{2,1,0}, '{8,5,2},
                                  '{7,4,1}, '{6,3,0}, '{8,4,0}, '{6,4,2}};

  logic clk = 1'b0;
  logic reset;
  move_arbiter_if bus_if ();

  move_arbiter #(.TIMEOUT_CYCLES(TO), .TW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  string scen     = "init";

  // Reference model state: phase, player on turn (0 = X, 1 = O), board cells
  // (0 empty, 1 X, 2 O), cycles spent in the current turn, pending square.
  int         m_phase, m_who, m_wait, m_pend;
  int         m_board [9];
  bit         m_arm [2];
  bit         e_ack [2];
  bit         e_nak [2];
  logic [1:0] m_result;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", scen, tag, obs, exp, $time);
    end
  endtask

  // External win checker behaviour: X=3, O=2, full board=1, else 0.
  function automatic logic [1:0] win_of(input logic [8:0] sq, input logic [8:0] pl);
    for (int l = 0; l < 8; l++) begin
      if (sq[LINES[l][0]] && sq[LINES[l][1]] && sq[LINES[l][2]]) begin
        if (pl[LINES[l][0]] && pl[LINES[l][1]] && pl[LINES[l][2]]) return 2'd3;
        if (!pl[LINES[l][0]] && !pl[LINES[l][1]] && !pl[LINES[l][2]]) return 2'd2;
      end
    end
    return (&sq) ? 2'd1 : 2'd0;
  endfunction

  assign bus_if.win_in = win_of(bus_if.occ_square, bus_if.occ_player);

  function automatic logic [8:0] m_sq();
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (m_board[i] != 0);
    return v;
  endfunction

  function automatic logic [8:0] m_pl();
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (m_board[i] == 1);
    return v;
  endfunction

  function automatic int sq_index(input logic [8:0] pos);
    for (int i = 0; i < 9; i++) if (pos[i]) return i;
    return 0;
  endfunction

  function automatic bit legal(input logic [8:0] pos);
    return ($countones(pos) == 1) && (m_board[sq_index(pos)] == 0);
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic rx,
                            input logic [8:0] px, input logic ro, input logic [8:0] po);
    logic [8:0] pos [2];
    bit req [2];
    bit seen [2];
    int p, q;
    logic [1:0] w;
    pos[0] = px; pos[1] = po; req[0] = rx; req[1] = ro;
    if (!rst) begin
      m_phase = P_IDLE; m_who = 0; m_wait = 0; m_pend = 0; m_result = 2'd0;
      for (int i = 0; i < 9; i++) m_board[i] = 0;
      for (int i = 0; i < 2; i++) begin m_arm[i] = 1'b1; e_ack[i] = 1'b0; e_nak[i] = 1'b0; end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      seen[i] = req[i] && m_arm[i];
      e_ack[i] = 1'b0;
      e_nak[i] = 1'b0;
    end
    p = m_who;
    q = 1 - m_who;
    case (m_phase)
      P_IDLE, P_OVER: if (st) begin
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_result = 2'd0; m_phase = P_TURN; m_who = 0; m_wait = 0;
      end
      P_TURN: begin
        if (seen[q]) e_nak[q] = 1'b1;
        if (seen[p] && legal(pos[p])) begin
          e_ack[p] = 1'b1; m_pend = sq_index(pos[p]); m_phase = P_COMMIT;
        end else begin
          if (seen[p]) e_nak[p] = 1'b1;
          m_wait++;
          if (m_wait == int'(TO) - 1) begin
            m_phase = P_OVER; m_result = (p == 0) ? 2'd2 : 2'd3;
          end
        end
      end
      P_COMMIT: begin
        if (seen[q]) e_nak[q] = 1'b1;
        m_board[m_pend] = p + 1;
        m_phase = P_CHECK;
      end
      P_CHECK: begin
        if (seen[q]) e_nak[q] = 1'b1;
        w = win_of(m_sq(), m_pl());
        if (w != 2'd0) begin
          m_phase = P_OVER; m_result = w;
        end else begin
          m_who = q; m_phase = P_TURN; m_wait = 0;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (e_ack[i] || e_nak[i]) m_arm[i] = 1'b0;
      else if (!req[i]) m_arm[i] = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [1:0] e_turn;
    e_turn = (m_phase != P_TURN) ? 2'b00 : ((m_who == 0) ? 2'b10 : 2'b01);
    check("ack_x", 32'(bus_if.ack_x), 32'(e_ack[0]));
    check("nak_x", 32'(bus_if.nak_x), 32'(e_nak[0]));
    check("ack_o", 32'(bus_if.ack_o), 32'(e_ack[1]));
    check("nak_o", 32'(bus_if.nak_o), 32'(e_nak[1]));
    check("occ_square", 32'(bus_if.occ_square), 32'(m_sq()));
    check("occ_player", 32'(bus_if.occ_player & bus_if.occ_square), 32'(m_pl()));
    check("turn", 32'(bus_if.turn), 32'(e_turn));
    check("result", 32'(bus_if.result), 32'(m_result));
    check("done", 32'(bus_if.done), 32'(m_phase == P_OVER));
  endtask

  // One clock: drive inputs, advance the model, check just after the edge.
  task automatic tick(input logic rst, input logic st, input logic rx,
                      input logic [8:0] px, input logic ro, input logic [8:0] po);
    reset         = rst;
    bus_if.start  = st;
    bus_if.req_x  = rx;
    bus_if.pos_x  = px;
    bus_if.req_o  = ro;
    bus_if.pos_o  = po;
    model_step(rst, st, rx, px, ro, po);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
  endtask

  task automatic new_game();
    tick(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
    tick(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
    tick(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
  endtask

  // Request one cycle, then let COMMIT and CHECK pass with req low.
  task automatic move(input bit is_x, input logic [8:0] pos);
    if (is_x) tick(1'b1, 1'b0, 1'b1, pos, 1'b0, 9'h000);
    else      tick(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, pos);
    idle(2);
  endtask

  function automatic logic [8:0] rand_pos();
    logic [8:0] one = 9'h001;
    if ($urandom_range(0, 3) != 0) return one << $urandom_range(0, 8);
    return 9'($urandom);
  endfunction

  initial begin
    int acks;
    reset = 1'b0;
    bus_if.start = 1'b0;
    bus_if.req_x = 1'b0; bus_if.pos_x = '0;
    bus_if.req_o = 1'b0; bus_if.pos_o = '0;

    scen = "reset";
    tick(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
    check("reset_turn", 32'(bus_if.turn), 32'd0);

    scen = "first_move";
    tick(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000);
    check("turn_x_open", 32'(bus_if.turn), 32'h2);
    tick(1'b1, 1'b0, 1'b1, 9'h010, 1'b0, 9'h000);
    check("ack_x_n1", 32'(bus_if.ack_x), 32'd1);
    idle(1);
    check("board_n2", 32'(bus_if.occ_square), 32'h010);
    idle(1);
    check("turn_o_n3", 32'(bus_if.turn), 32'h1);

    scen = "o_bad_moves";
    tick(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h010);
    check("nak_o_occupied", 32'(bus_if.nak_o), 32'd1);
    idle(1);
    tick(1'b1, 1'b0, 1'b0, 9'h000, 1'b1, 9'h003);
    check("nak_o_twohot", 32'(bus_if.nak_o), 32'd1);
    idle(1);
    check("turn_still_o", 32'(bus_if.turn), 32'h1);

    scen = "x_wins";
    new_game();
    move(1'b1, 9'h100); move(1'b0, 9'h001);
    move(1'b1, 9'h080); move(1'b0, 9'h002);
    move(1'b1, 9'h040);
    check("winx", 32'(bus_if.result), 32'd3);
    check("done_winx", 32'(bus_if.done), 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, i[0], 9'h004, ~i[0], 9'h008);

    scen = "timeout";
    new_game();
    idle(14);
    check("not_yet_over", 32'(bus_if.done), 32'd0);
    idle(1);
    check("timeout_over", 32'(bus_if.done), 32'd1);
    check("timeout_wino", 32'(bus_if.result), 32'd2);

    scen = "simultaneous";
    new_game();
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 1'b1, 9'h100, (i == 0), 9'h001);
      acks += int'(bus_if.ack_x);
    end
    check("single_ack_x", 32'(acks), 32'd1);

    scen = "reset_in_commit";
    new_game();
    tick(1'b1, 1'b0, 1'b1, 9'h010, 1'b0, 9'h000);
    tick(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000);
    check("board_cleared", 32'(bus_if.occ_square), 32'd0);
    idle(2);

    scen = "random";
    for (int i = 0; i < 2500; i++) begin
      tick(($urandom_range(0, 299) != 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), rand_pos(), 1'($urandom_range(0, 1)), rand_pos());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
